// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: branch predictor lookup, in-flight branch FIFO and table update control
module bp_update_ctrl #(
    parameter int PC_WIDTH  = 16,
    parameter int IDX_WIDTH = 4,
    parameter int Q_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_fetch_valid,
    input  logic [PC_WIDTH-1:0]  fetch_pc,
    output logic                 fetch_stall,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 res_valid,
    input  logic                 res_taken,
    input  logic [PC_WIDTH-1:0]  res_target,
    input  logic                 flush,
    output logic                 res_err,
    output logic [IDX_WIDTH-1:0] pht_rd_addr1,
    output logic [IDX_WIDTH-1:0] pht_rd_addr2,
    input  logic [1:0]           pht_rd_data1,
    input  logic [1:0]           pht_rd_data2,
    output logic [IDX_WIDTH-1:0] tag_rd_addr,
    input  logic [PC_WIDTH-1:0]  tag_rd_data,
    output logic [IDX_WIDTH-1:0] tgt_rd_addr,
    input  logic [PC_WIDTH-1:0]  tgt_rd_data,
    output logic                 pht_wr,
    output logic [IDX_WIDTH-1:0] pht_wr_addr,
    output logic [1:0]           pht_wr_data,
    output logic                 btb_wr,
    output logic [IDX_WIDTH-1:0] btb_wr_addr,
    output logic [PC_WIDTH-1:0]  btb_wr_tag,
    output logic [PC_WIDTH-1:0]  btb_wr_tgt
);
    localparam int PW = Q_DEPTH > 1 ? $clog2(Q_DEPTH) : 1;
    localparam int CW = $clog2(Q_DEPTH + 1);

    logic [PC_WIDTH-1:0]  q [Q_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop, hit;
    logic [PC_WIDTH-1:0]  head_pc;
    logic [IDX_WIDTH-1:0] fetch_idx, head_idx;
    logic [1:0]           cur, nxt;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(Q_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign fetch_idx    = fetch_pc[IDX_WIDTH-1:0];
    assign pht_rd_addr1 = fetch_idx;
    assign tag_rd_addr  = fetch_idx;
    assign tgt_rd_addr  = fetch_idx;
    assign hit          = tag_rd_data == fetch_pc && fetch_pc != '1;
    // a pop in the same cycle does not free a slot for the push
    assign fetch_stall  = count == CW'(Q_DEPTH);
    assign push         = br_fetch_valid && !fetch_stall && !flush;
    assign pop          = res_valid && count != '0;
    assign head_pc      = q[rd_ptr];
    assign head_idx     = head_pc[IDX_WIDTH-1:0];
    assign pht_rd_addr2 = head_idx;
    // the table has not yet absorbed a write that is on the port this cycle
    assign cur          = pht_wr && pht_wr_addr == head_idx ? pht_wr_data : pht_rd_data2;
    assign nxt          = res_taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                    : (cur == 2'b00 ? cur : cur - 2'd1);

    // fifo storage; contents are meaningless outside the count window so no reset
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= fetch_pc;
    end

    // fifo occupancy and pointers; flush empties after the same-cycle pop is taken
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
            rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
            wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
        end
    end

    // registered prediction; taken/target hold between accepted fetches
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_valid <= push;
            if (push) begin
                pred_taken  <= hit && pht_rd_data1[1];
                pred_target <= hit ? tgt_rd_data : '0;
            end
        end
    end

    // single-cycle table write pulses issued from a resolve of the queue head
    always_ff @(posedge clk) begin
        if (reset) begin
            pht_wr      <= 1'b0;
            pht_wr_addr <= '0;
            pht_wr_data <= '0;
            btb_wr      <= 1'b0;
            btb_wr_addr <= '0;
            btb_wr_tag  <= '0;
            btb_wr_tgt  <= '0;
        end else begin
            pht_wr <= pop;
            btb_wr <= pop && res_taken;
            if (pop) begin
                pht_wr_addr <= head_idx;
                pht_wr_data <= nxt;
            end
            if (pop && res_taken) begin
                btb_wr_addr <= head_idx;
                btb_wr_tag  <= head_pc;
                btb_wr_tgt  <= res_target;
            end
        end
    end

    // sticky error for a resolve with nothing outstanding
    always_ff @(posedge clk) begin
        if (reset) res_err <= 1'b0;
        else if (res_valid && count == '0) res_err <= 1'b1;
    end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed scoreboard bench for bp_update_ctrl with modelled predictor tables
module tb_bp_update_ctrl;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        reset, br_fetch_valid, res_valid, res_taken, flush;
    logic [15:0] fetch_pc, res_target;
    logic        fetch_stall, pred_valid, pred_taken, res_err;
    logic [15:0] pred_target;
    logic [3:0]  pht_rd_addr1, pht_rd_addr2, tag_rd_addr, tgt_rd_addr;
    logic [1:0]  pht_rd_data1, pht_rd_data2;
    logic [15:0] tag_rd_data, tgt_rd_data;
    logic        pht_wr, btb_wr;
    logic [3:0]  pht_wr_addr, btb_wr_addr;
    logic [1:0]  pht_wr_data;
    logic [15:0] btb_wr_tag, btb_wr_tgt;

    always #5 clk = ~clk;

    bp_update_ctrl #(.PC_WIDTH(16), .IDX_WIDTH(4), .Q_DEPTH(QD)) dut (
        .clk(clk), .reset(reset), .br_fetch_valid(br_fetch_valid), .fetch_pc(fetch_pc),
        .fetch_stall(fetch_stall), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .res_valid(res_valid), .res_taken(res_taken),
        .res_target(res_target), .flush(flush), .res_err(res_err),
        .pht_rd_addr1(pht_rd_addr1), .pht_rd_addr2(pht_rd_addr2),
        .pht_rd_data1(pht_rd_data1), .pht_rd_data2(pht_rd_data2),
        .tag_rd_addr(tag_rd_addr), .tag_rd_data(tag_rd_data),
        .tgt_rd_addr(tgt_rd_addr), .tgt_rd_data(tgt_rd_data),
        .pht_wr(pht_wr), .pht_wr_addr(pht_wr_addr), .pht_wr_data(pht_wr_data),
        .btb_wr(btb_wr), .btb_wr_addr(btb_wr_addr), .btb_wr_tag(btb_wr_tag),
        .btb_wr_tgt(btb_wr_tgt)
    );

    // predictor tables the DUT drives: combinational reads, synchronous writes
    logic [1:0]  e_pht [16];
    logic [15:0] e_tag [16];
    logic [15:0] e_tgt [16];
    assign pht_rd_data1 = e_pht[pht_rd_addr1];
    assign pht_rd_data2 = e_pht[pht_rd_addr2];
    assign tag_rd_data  = e_tag[tag_rd_addr];
    assign tgt_rd_data  = e_tgt[tgt_rd_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                e_pht[k] <= 2'b01;
                e_tag[k] <= 16'hffff;
                e_tgt[k] <= 16'h0000;
            end
        end else begin
            if (pht_wr) e_pht[pht_wr_addr] <= pht_wr_data;
            if (btb_wr) begin
                e_tag[btb_wr_addr] <= btb_wr_tag;
                e_tgt[btb_wr_addr] <= btb_wr_tgt;
            end
        end
    end

    typedef struct packed {
        logic        pv;
        logic        pt;
        logic [15:0] ptgt;
        logic        pw;
        logic [3:0]  pa;
        logic [1:0]  pd;
        logic        bw;
        logic [3:0]  ba;
        logic [15:0] btag;
        logic [15:0] btgt;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] mq [$];
    logic [1:0]  m_pht [16];
    logic [15:0] m_tag [16];
    logic [15:0] m_tgt [16];
    logic [1:0]  t_pht [16];
    logic [15:0] t_tag [16];
    logic [15:0] t_tgt [16];
    logic        p_v, p_b, h_pt, m_err;
    logic [3:0]  p_i;
    logic [1:0]  p_d;
    logic [15:0] p_tag, p_tgt, h_ptgt;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_pht[k] = 2'b01; m_tag[k] = 16'hffff; m_tgt[k] = 16'h0000;
            t_pht[k] = 2'b01; t_tag[k] = 16'hffff; t_tgt[k] = 16'h0000;
        end
        mq.delete();
        p_v = 1'b0; p_b = 1'b0; p_i = '0; p_d = '0; p_tag = '0; p_tgt = '0;
        h_pt = 1'b0; h_ptgt = '0; m_err = 1'b0;
    endtask

    // one clock of stimulus: expectation pushed when driven, popped and compared after the edge
    task automatic cyc(input logic rst, input logic fv, input logic [15:0] fpc,
                       input logic rv, input logic rt, input logic [15:0] rtgt, input logic fl);
        exp_t        e;
        logic        push, pop, hit;
        logic [3:0]  i;
        logic [1:0]  n;
        logic [15:0] hp;
        @(negedge clk);
        reset = rst; br_fetch_valid = fv; fetch_pc = fpc;
        res_valid = rv; res_taken = rt; res_target = rtgt; flush = fl;
        #1;
        e = '0;
        if (rst) model_reset();
        else begin
            chk("fetch_stall", {15'd0, fetch_stall}, {15'd0, mq.size() == QD});
            push = fv && mq.size() < QD && !fl;
            pop  = rv && mq.size() > 0;
            if (push) begin
                i = fpc[3:0];
                hit = t_tag[i] == fpc && fpc != 16'hffff;
                h_pt = hit && t_pht[i][1];
                h_ptgt = hit ? t_tgt[i] : 16'h0000;
            end
            e.pv = push; e.pt = h_pt; e.ptgt = h_ptgt;
            if (p_v) t_pht[p_i] = p_d;
            if (p_b) begin t_tag[p_i] = p_tag; t_tgt[p_i] = p_tgt; end
            p_v = 1'b0; p_b = 1'b0;
            if (pop) begin
                hp = mq.pop_front();
                i = hp[3:0];
                n = rt ? (m_pht[i] == 2'd3 ? 2'd3 : m_pht[i] + 2'd1)
                       : (m_pht[i] == 2'd0 ? 2'd0 : m_pht[i] - 2'd1);
                m_pht[i] = n;
                e.pw = 1'b1; e.pa = i; e.pd = n;
                p_v = 1'b1; p_i = i; p_d = n;
                if (rt) begin
                    m_tag[i] = hp; m_tgt[i] = rtgt;
                    e.bw = 1'b1; e.ba = i; e.btag = hp; e.btgt = rtgt;
                    p_b = 1'b1; p_tag = hp; p_tgt = rtgt;
                end
            end else if (rv) m_err = 1'b1;
            if (fl) mq.delete();
            if (push) mq.push_back(fpc);
            e.err = m_err;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pred_valid", {15'd0, pred_valid}, {15'd0, e.pv});
        chk("pred_taken", {15'd0, pred_taken}, {15'd0, e.pt});
        chk("pred_target", pred_target, e.ptgt);
        chk("pht_wr", {15'd0, pht_wr}, {15'd0, e.pw});
        if (e.pw) begin
            chk("pht_wr_addr", {12'd0, pht_wr_addr}, {12'd0, e.pa});
            chk("pht_wr_data", {14'd0, pht_wr_data}, {14'd0, e.pd});
        end
        chk("btb_wr", {15'd0, btb_wr}, {15'd0, e.bw});
        if (e.bw) begin
            chk("btb_wr_addr", {12'd0, btb_wr_addr}, {12'd0, e.ba});
            chk("btb_wr_tag", btb_wr_tag, e.btag);
            chk("btb_wr_tgt", btb_wr_tgt, e.btgt);
        end
        chk("res_err", {15'd0, res_err}, {15'd0, e.err});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic fetch(input logic [15:0] pc);
        cyc(1'b0, 1'b1, pc, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic resolve(input logic t, input logic [15:0] tgt);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, t, tgt, 1'b0);
    endtask

    initial begin
        reset = 1'b1; br_fetch_valid = 1'b0; fetch_pc = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0; flush = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        // cold lookup, then train idx 3 and look it up again
        fetch(16'h0013);
        resolve(1'b1, 16'h0040);
        idle();
        idle();
        fetch(16'h0013);
        resolve(1'b0, 16'h0000);
        idle();
        // saturation up through forwarding, then down
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        fetch(16'h0003); fetch(16'h0013); fetch(16'h0103); fetch(16'h1003);
        resolve(1'b1, 16'h0050); resolve(1'b1, 16'h0051);
        resolve(1'b1, 16'h0052); resolve(1'b1, 16'h0053);
        fetch(16'h0003); fetch(16'h1003); fetch(16'h2003); fetch(16'h0013);
        resolve(1'b0, 16'h0000); resolve(1'b0, 16'h0000);
        resolve(1'b0, 16'h0000); resolve(1'b0, 16'h0000);
        fetch(16'h0023);
        resolve(1'b0, 16'h0000);
        idle();
        // fill to full, refused fetch, push+pop while full, wrap, in-order drain
        fetch(16'h0021); fetch(16'h0022); fetch(16'h0023); fetch(16'h0024);
        fetch(16'h0025);
        cyc(1'b0, 1'b1, 16'h0026, 1'b1, 1'b1, 16'h0100, 1'b0);
        fetch(16'h0027);
        fetch(16'h0028);
        resolve(1'b1, 16'h0101); resolve(1'b0, 16'h0000);
        resolve(1'b1, 16'h0103); resolve(1'b1, 16'h0104);
        idle();
        fetch(16'h0022);
        // flush with a simultaneous resolve and dropped fetch, then an empty resolve
        fetch(16'h0031); fetch(16'h0032);
        cyc(1'b0, 1'b1, 16'h0034, 1'b1, 1'b1, 16'h0200, 1'b1);
        resolve(1'b1, 16'h0201);
        idle();
        fetch(16'h0041); fetch(16'h0042); fetch(16'h0043); fetch(16'h0044);
        fetch(16'h0045);
        resolve(1'b1, 16'h0300); resolve(1'b0, 16'h0000);
        // reset mid-operation with two queued and a resolve in flight
        cyc(1'b1, 1'b1, 16'h0051, 1'b1, 1'b1, 16'h0400, 1'b0);
        idle();
        resolve(1'b1, 16'h0401);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Branch-predictor controller that sits directly around the predictor tables: the 2-bit pattern-history table, the tag table and the target table, each a register-file instance with combinational reads and synchronous writes.
- At fetch it looks up the tables and registers a prediction.
- It holds in-flight branch predictions in a small FIFO.
- At branch resolution it computes the saturating-counter and tag/target updates and drives the table write ports.

Parameters:
- PC_WIDTH, 16, fetch/branch PC width (word address).
- IDX_WIDTH, 4, table index width; table depth is 2**IDX_WIDTH.
- Q_DEPTH, 4, maximum number of unresolved predicted branches.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- br_fetch_valid  in  1  a branch is in fetch this cycle
- fetch_pc  in  PC_WIDTH  PC of that branch
- fetch_stall  out  1  queue full; br_fetch_valid is ignored
- pred_valid/pred_taken  out  1/1  registered prediction
- pred_target  out  PC_WIDTH  registered predicted target
- res_valid  in  1  oldest branch resolved
- res_taken  in  1  actual outcome
- res_target  in  PC_WIDTH  actual target
- flush  in  1  discard all queued predictions
- res_err  out  1  sticky: resolve arrived with the queue empty
- pht_rd_addr1/pht_rd_addr2  out  IDX_WIDTH  fetch-lookup / resolve-lookup read addresses
- pht_rd_data1/pht_rd_data2  in  2  counter values
- tag_rd_addr  out  IDX_WIDTH; tag_rd_data  in  PC_WIDTH
- tgt_rd_addr  out  IDX_WIDTH; tgt_rd_data  in  PC_WIDTH
- pht_wr  out  1; pht_wr_addr  out  IDX_WIDTH; pht_wr_data  out  2
- btb_wr  out  1  writes the tag and target tables together
- btb_wr_addr  out  IDX_WIDTH
- btb_wr_tag, btb_wr_tgt  out  PC_WIDTH

Behaviour:
- Table conventions:
  - idx = pc[IDX_WIDTH-1:0].
  - Counter encoding: 00 SNT, 01 WNT (table reset value), 10 WT, 11 ST.
  - Tag value all-ones (16'hffff, the tag-table reset value) means invalid; PC all-ones never hits.
- Lookup:
  - pht_rd_addr1, tag_rd_addr and tgt_rd_addr are driven from fetch_pc.
  - hit = (tag_rd_data == fetch_pc) and fetch_pc != all-ones.
- Prediction (latency 1): on an accepted fetch (br_fetch_valid & !fetch_stall), at the next posedge:
  - pred_valid = 1.
  - pred_taken = hit & pht_rd_data1[1].
  - pred_target = hit ? tgt_rd_data : 0.
  - Otherwise pred_valid = 0 and the other pred outputs hold their previous values.
- Queue:
  - Circular FIFO, Q_DEPTH entries of {pc}, with count 0..Q_DEPTH and rd/wr pointers that wrap modulo Q_DEPTH.
  - Accepted fetch pushes; res_valid with count > 0 pops the head.
  - fetch_stall = (count == Q_DEPTH), combinational. It does not drop when a pop occurs in the same cycle, so a push is refused whenever the queue is full.
  - A push and a pop in the same cycle leave count unchanged.
- Resolve:
  - pht_rd_addr2 = head.pc idx.
  - cur = forwarded value if pht_wr is currently asserted with pht_wr_addr equal to head idx, else pht_rd_data2.
  - next = taken ? min(cur+1, 3) : max(cur-1, 0).
  - At the next posedge: pht_wr = 1, pht_wr_addr = head idx, pht_wr_data = next.
  - If res_taken: btb_wr = 1, btb_wr_addr = head idx, btb_wr_tag = head.pc, btb_wr_tgt = res_target.
  - All write strobes are single-cycle pulses; there is no table write without a resolve.
- Empty resolve: res_valid with count == 0 produces no writes and no pop, and sets res_err (cleared only by reset).
- Flush:
  - Sets count = 0 and resets the pointers at the posedge.
  - A res_valid in the same cycle is processed first (its update is still issued the next cycle).
  - A push in the same cycle is dropped.
  - pred_valid is 0 the cycle after a flush.
  - An already-registered write still completes.
- Reset (takes priority over everything):
  - count and pointers = 0.
  - All write strobes, pred_valid, pred_taken and res_err = 0.
  - pred_target, write address and write data outputs = 0.
  - Reset asserted mid-operation discards queued branches and any pending write.

Test Plan:
- Reset tables (PHT=01, tags=ffff), fetch pc 0x0013 -> pred_valid=1 next cycle, pred_taken=0, pred_target=0; fetch_stall=0.
- Resolve pc 0x0013 taken, target 0x0040 -> next cycle pht_wr=1, addr 3, data 10; btb_wr=1, tag 0x0013, tgt 0x0040. Re-fetch 0x0013 -> pred_taken=1, pred_target=0x0040.
- Saturation:
  - Four taken resolves of idx 3 back-to-back: writes 10, 11, 11, 11, exercising forwarding.
  - Then five not-taken resolves: writes 10, 01, 00, 00, 00.
- Fetch 5 branches with no resolve (Q_DEPTH=4) -> fetch_stall=1 after the 4th; 5th ignored. Then push+pop while full -> push refused, count becomes 3. Resolve order matches fetch order across pointer wrap.
- flush with 3 queued plus a simultaneous res_valid -> one update write issued, count=0. A following res_valid -> no write, res_err=1.
- Assert reset with 2 queued and a write pending -> no write strobe the next cycle, count=0, res_err=0, pred_valid=0.
